// File: rtl/tetris_pkg.sv
// Shared playfield dimensions, cell/grid types, colour codes and the
// line-clear FSM state encoding.
package tetris_pkg;

    localparam int ROWS   = 20;
    localparam int COLS   = 10;
    localparam int CELL_W = 4;

    typedef logic [CELL_W-1:0] cell_t;
    typedef cell_t [ROWS-1:0][COLS-1:0] grid_t;

    localparam cell_t EMPTY   = cell_t'(0);
    localparam cell_t COLOR_I = cell_t'(1);
    localparam cell_t COLOR_O = cell_t'(2);
    localparam cell_t COLOR_T = cell_t'(3);
    localparam cell_t COLOR_S = cell_t'(4);
    localparam cell_t COLOR_Z = cell_t'(5);
    localparam cell_t COLOR_J = cell_t'(6);
    localparam cell_t COLOR_L = cell_t'(7);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/row_full_detect.sv
// Flags a playfield row whose every cell holds a non-zero colour code.
module row_full_detect #(
    parameter int COLS   = 10,
    parameter int CELL_W = 4
) (
    input  logic [COLS-1:0][CELL_W-1:0] row_cells,
    output logic                        full
);

    // AND-reduce the per-cell occupied flags.
    always_comb begin
        full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (row_cells[c] == '0) full = 1'b0;
        end
    end

endmodule

// File: rtl/grid_line_clear.sv
// Playfield storage: writes one locked piece per handshake, then scans
// bottom-to-top collapsing full rows and reports the number cleared.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a locked piece; lock_ready high unless clr_all
// ST_WRITE | write the captured cells into the grid
// ST_SCAN  | test row scan_row for full; move up one row when not full
// ST_SHIFT | collapse rows scan_row..1 down by one, top row cleared
// ST_DONE  | pulse clear_done, publish line counts
module grid_line_clear
    import tetris_pkg::*;
#(
    parameter int ROWS   = tetris_pkg::ROWS,
    parameter int COLS   = tetris_pkg::COLS,
    parameter int CELL_W = tetris_pkg::CELL_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clr_all,
    input  logic                                     lock_valid,
    output logic                                     lock_ready,
    input  logic [3:0][4:0]                          lock_row,
    input  logic [3:0][3:0]                          lock_col,
    input  logic [CELL_W-1:0]                        lock_color,
    output logic [ROWS-1:0][COLS-1:0][CELL_W-1:0]    game_grid_array,
    output logic                                     busy,
    output logic                                     clear_done,
    output logic [2:0]                               lines_cleared,
    output logic [15:0]                              total_lines
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t                               state, state_nx;
    logic [ROWS-1:0][COLS-1:0][CELL_W-1:0] grid;
    logic [3:0][4:0]                      cap_row;
    logic [3:0][3:0]                      cap_col;
    logic [CELL_W-1:0]                    cap_color;
    logic [RW-1:0]                        scan_row;
    logic [2:0]                           line_cnt;
    logic                                 row_full;
    logic                                 handshake;
    logic [16:0]                          total_sum;

    row_full_detect #(
        .COLS   (COLS),
        .CELL_W (CELL_W)
    ) u_row_full (
        .row_cells (grid[scan_row]),
        .full      (row_full)
    );

    assign game_grid_array = grid;
    assign handshake       = lock_valid && lock_ready;
    assign total_sum       = 17'(total_lines) + 17'(line_cnt);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and Moore outputs; clr_all overrides everything.
    always_comb begin
        state_nx   = state;
        lock_ready = (state == ST_IDLE) && !clr_all;
        busy       = (state != ST_IDLE);
        clear_done = 1'b0;
        case (state)
            ST_IDLE:  if (lock_valid && lock_ready) state_nx = ST_WRITE;
            ST_WRITE: state_nx = ST_SCAN;
            ST_SCAN: begin
                if (row_full)              state_nx = ST_SHIFT;
                else if (scan_row == '0)   state_nx = ST_DONE;
            end
            ST_SHIFT: state_nx = ST_SCAN;
            ST_DONE: begin
                clear_done = 1'b1;
                state_nx   = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
        if (clr_all) state_nx = ST_IDLE;
    end

    // Grid, capture registers, scan pointer and line counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grid          <= '0;
            cap_row       <= '0;
            cap_col       <= '0;
            cap_color     <= '0;
            scan_row      <= '0;
            line_cnt      <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else if (clr_all) begin
            grid          <= '0;
            line_cnt      <= '0;
            lines_cleared <= '0;
            total_lines   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (handshake) begin
                        cap_row   <= lock_row;
                        cap_col   <= lock_col;
                        cap_color <= lock_color;
                        line_cnt  <= '0;
                    end
                end
                ST_WRITE: begin
                    // Later iterations override earlier ones, so the
                    // higher cell index wins on duplicate coordinates.
                    for (int i = 0; i < 4; i++) begin
                        if (32'(cap_row[i]) < ROWS && 32'(cap_col[i]) < COLS)
                            grid[cap_row[i]][cap_col[i]] <= cap_color;
                    end
                    scan_row <= RW'(ROWS - 1);
                end
                ST_SCAN: begin
                    if (!row_full && scan_row != '0) scan_row <= scan_row - 1'b1;
                end
                ST_SHIFT: begin
                    for (int r = 1; r < ROWS; r++) begin
                        if (r <= int'(scan_row)) grid[r] <= grid[r-1];
                    end
                    grid[0] <= '0;
                    if (line_cnt != 3'd7) line_cnt <= line_cnt + 3'd1;
                end
                ST_DONE: begin
                    lines_cleared <= line_cnt;
                    total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule
